// File: rtl/spi_lcd_rx.sv
// SPI mode-0 slave receiver for the 4-wire LCD link (CSX, DCX, SCK, SDI).
// Bytes are captured MSB first, tagged with their DCX level and queued in a
// small FIFO. The CPU sees one 16-bit status/data word and controls the
// receiver through the load/in IO slot.
//
// CPU handshake: 'load' is a single-cycle write strobe with no back-pressure.
// Every cycle with load = 1 is one accepted write. in[0] pops the FIFO head
// (ignored when empty) and in[1] clears the sticky error flags. A pop shows
// up in 'out' on the following clk.
module spi_lcd_rx #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   input  logic        CSX,
   input  logic        DCX,
   input  logic        SCK,
   input  logic        SDI
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Synchronizer chains: new samples enter at bit 0, the synced value is the MSB.
   logic [SYNC_STAGES-1:0] csx_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;
   logic [SYNC_STAGES-1:0] dcx_sync;
   logic                   sck_prev;
   logic                   dcx_dly;

   logic csx_s;
   logic sck_s;
   logic sdi_s;
   logic sck_rise;

   // Receiver FSM state; kept as a named signal so it can be probed directly.
   logic [0:0] state;
   logic [0:0] state_n;
   logic [2:0] bitcnt;
   logic [2:0] bitcnt_n;
   logic [7:0] shift;
   logic [7:0] shift_n;

   logic       push_req;
   logic       ferr_set;
   logic [8:0] push_data;

   // FIFO storage and bookkeeping.
   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [3:0]    level;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          ovf_set;
   logic          flag_clr;

   logic overflow;
   logic frame_err;

   // Only in[1:0] carry meaning; the rest is deliberately ignored.
   logic unused_in;
   assign unused_in = ^in[15:2];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Bring the asynchronous SPI pins into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csx_sync <= '1;
         sck_sync <= '0;
         sdi_sync <= '0;
         dcx_sync <= '0;
         sck_prev <= 1'b0;
         dcx_dly  <= 1'b0;
      end else begin
         csx_sync <= {csx_sync[SYNC_STAGES-2:0], CSX};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
         dcx_sync <= {dcx_sync[SYNC_STAGES-2:0], DCX};
         sck_prev <= sck_sync[SYNC_STAGES-1];
         dcx_dly  <= dcx_sync[SYNC_STAGES-1];
      end
   end

   assign csx_s    = csx_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;

   // The completed byte includes the bit arriving on this edge.
   assign push_data = {dcx_dly, shift[6:0], sdi_s};

   // Next-state logic: bit capture, byte completion and CSX framing.
   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      shift_n  = shift;
      push_req = 1'b0;
      ferr_set = 1'b0;
      case (state)
         IDLE: begin
            if (!csx_s) begin
               state_n  = SHIFT;
               bitcnt_n = 3'd0;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               shift_n  = {shift[6:0], sdi_s};
               bitcnt_n = bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  push_req = 1'b1;
                  bitcnt_n = 3'd0;
               end
            end
            // A byte finishing on the same clk as CSX rising is still whole.
            if (csx_s) begin
               state_n = IDLE;
               if (bitcnt_n != 3'd0) begin
                  ferr_set = 1'b1;
               end
               bitcnt_n = 3'd0;
            end
         end
         default: begin
            state_n  = IDLE;
            bitcnt_n = 3'd0;
         end
      endcase
   end

   // FSM and shift register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         bitcnt <= 3'd0;
         shift  <= 8'd0;
      end else begin
         state  <= state_n;
         bitcnt <= bitcnt_n;
         shift  <= shift_n;
      end
   end

   assign empty    = (level == 4'd0);
   assign full     = (level == 4'(DEPTH));
   assign pop      = load & in[0] & ~empty;
   assign flag_clr = load & in[1];
   // A pop on the same clk frees the slot, so a full FIFO still accepts.
   assign push_ok  = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   // Circular FIFO with wrap-around pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= 4'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 9'd0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (push_ok && !pop) begin
            level <= level + 4'd1;
         end else if (pop && !push_ok) begin
            level <= level - 4'd1;
         end
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (flag_clr) begin
            overflow <= 1'b0;
         end
         if (ferr_set) begin
            frame_err <= 1'b1;
         end else if (flag_clr) begin
            frame_err <= 1'b0;
         end
      end
   end

   assign out = {~empty, overflow, frame_err, level, (empty ? 9'd0 : mem[rd_ptr])};

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: table of single-byte frames plus hand
// sequences for multi-byte frames, overflow, framing errors, push/pop
// collisions, CSX/last-edge coincidence and reset in the middle of a byte.
module tb_spi_lcd_rx;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        csx;
   logic        dcx;
   logic        sck;
   logic        sdi;

   int total;
   int bad;

   logic [8:0] exp_q[$];

   typedef struct {
      logic [7:0]  data;
      logic        dcx;
      logic [15:0] exp_out;
   } vec_t;

   vec_t vecs[5];

   spi_lcd_rx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .in    (in),
      .out   (out),
      .CSX   (csx),
      .DCX   (dcx),
      .SCK   (sck),
      .SDI   (sdi)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // mode 0: plain; 1: CPU pop lands on the clk the byte is pushed;
   // 2: CSX rises together with the last SCK edge; 3: check latency of last bit.
   task automatic send_bits(input logic [7:0] d, input logic dc, input int nbits, input int mode);
      for (int i = 0; i < nbits; i++) begin
         sdi = d[7-i];
         dcx = dc;
         repeat (4) @(negedge clk);
         sck = 1'b1;
         if (i == nbits - 1 && mode == 1) begin
            repeat (2) @(negedge clk);
            load = 1'b1;
            in   = 16'h0001;
            @(negedge clk);
            load = 1'b0;
            in   = 16'h0000;
            @(negedge clk);
         end else if (i == nbits - 1 && mode == 2) begin
            csx = 1'b1;
            repeat (4) @(negedge clk);
         end else if (i == nbits - 1 && mode == 3) begin
            repeat (4) @(negedge clk);
            check("latency", {15'd0, out[15]}, 16'h0001);
         end else begin
            repeat (4) @(negedge clk);
         end
         sck = 1'b0;
      end
   endtask

   task automatic do_frame(input logic [7:0] d, input logic dc, input int mode);
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(d, dc, 8, mode);
      repeat (4) @(negedge clk);
      csx = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic cpu_write(input logic [15:0] v);
      load = 1'b1;
      in   = v;
      @(negedge clk);
      load = 1'b0;
      in   = 16'h0000;
   endtask

   // Scoreboard: pop every expected entry and compare the head word.
   task automatic drain();
      logic [8:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("drain_head", {out[15], 6'd0, out[8:0]}, {1'b1, 6'd0, e});
         cpu_write(16'h0001);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{8'hA5, 1'b0, 16'h82A5};
      vecs[1] = '{8'h3C, 1'b1, 16'h833C};
      vecs[2] = '{8'h00, 1'b1, 16'h8300};
      vecs[3] = '{8'hFF, 1'b0, 16'h82FF};
      vecs[4] = '{8'h81, 1'b1, 16'h8381};

      reset = 1'b1;
      load  = 1'b0;
      in    = 16'h0000;
      csx   = 1'b1;
      dcx   = 1'b0;
      sck   = 1'b0;
      sdi   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", out, 16'h0000);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Single-byte frames from the table.
      foreach (vecs[k]) begin
         do_frame(vecs[k].data, vecs[k].dcx, 0);
         check("vec_out", out, vecs[k].exp_out);
         cpu_write(16'h0001);
         check("vec_pop", out, 16'h0000);
      end

      // Latency from the last physical SCK edge.
      do_frame(8'h96, 1'b0, 3);
      check("lat_out", out, 16'h8296);
      cpu_write(16'h0001);

      // One frame, three bytes, command then data.
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(8'h2C, 1'b0, 8, 0);
      send_bits(8'h12, 1'b1, 8, 0);
      send_bits(8'h34, 1'b1, 8, 0);
      repeat (4) @(negedge clk);
      csx = 1'b1;
      repeat (6) @(negedge clk);
      exp_q.push_back(9'h02C);
      exp_q.push_back(9'h112);
      exp_q.push_back(9'h134);
      check("multi_out", out, 16'h862C);
      drain();
      check("multi_empty", out, 16'h0000);

      // Overflow: five bytes into four slots.
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(8'h11, 1'b1, 8, 0);
      send_bits(8'h22, 1'b1, 8, 0);
      send_bits(8'h33, 1'b1, 8, 0);
      send_bits(8'h44, 1'b1, 8, 0);
      send_bits(8'h55, 1'b1, 8, 0);
      repeat (4) @(negedge clk);
      csx = 1'b1;
      repeat (6) @(negedge clk);
      exp_q.push_back(9'h111);
      exp_q.push_back(9'h122);
      exp_q.push_back(9'h133);
      exp_q.push_back(9'h144);
      check("ovf_out", out, 16'hC911);
      drain();
      check("ovf_empty", out, 16'h4000);
      cpu_write(16'h0002);
      check("ovf_clear", out, 16'h0000);

      // Frame error: CSX rises after five bits.
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(8'hF0, 1'b0, 5, 0);
      repeat (4) @(negedge clk);
      csx = 1'b1;
      repeat (6) @(negedge clk);
      check("ferr_out", out, 16'h2000);
      do_frame(8'h5A, 1'b0, 0);
      check("ferr_next", out, 16'hA25A);
      cpu_write(16'h0003);
      check("ferr_clear", out, 16'h0000);

      // Full FIFO with a pop on the same clk as the incoming push.
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(8'hA1, 1'b0, 8, 0);
      send_bits(8'hA2, 1'b0, 8, 0);
      send_bits(8'hA3, 1'b0, 8, 0);
      send_bits(8'hA4, 1'b0, 8, 0);
      repeat (2) @(negedge clk);
      check("full_out", out, 16'h88A1);
      send_bits(8'hB5, 1'b1, 8, 1);
      repeat (4) @(negedge clk);
      csx = 1'b1;
      repeat (6) @(negedge clk);
      check("pushpop_out", out, 16'h88A2);
      exp_q.push_back(9'h0A2);
      exp_q.push_back(9'h0A3);
      exp_q.push_back(9'h0A4);
      exp_q.push_back(9'h1B5);
      drain();
      check("pushpop_empty", out, 16'h0000);

      // CSX rises on the same clk the eighth edge is seen.
      do_frame(8'hC3, 1'b0, 2);
      check("csx_edge_out", out, 16'h82C3);
      cpu_write(16'h0001);
      check("csx_edge_pop", out, 16'h0000);

      // Reset in the middle of a byte with data queued.
      do_frame(8'h77, 1'b1, 0);
      check("pre_reset", out, 16'h8377);
      csx = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(8'hFF, 1'b1, 4, 0);
      reset = 1'b1;
      #1;
      check("reset_async", out, 16'h0000);
      @(negedge clk);
      csx = 1'b1;
      sck = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_idle", out, 16'h0000);
      do_frame(8'h3C, 1'b1, 0);
      check("post_reset_byte", out, 16'h833C);
      cpu_write(16'h0001);
      check("post_reset_pop", out, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
